exmem_stage: RTL
================

EXMEM_STAGE -- requirements
Module: exmem_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width of result, store data and PCs.
REQ-002 SHALL have parameter SQUASH_CNT, default 2, number of younger instructions killed after a taken branch (1..3).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  execute stage presents an instruction.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port in_result  input  WIDTH  ALU result.
REQ-008 SHALL have port in_taken  input  1  ALU branch condition true.
REQ-009 SHALL have port in_is_branch  input  1  instruction is a conditional branch.
REQ-010 SHALL have port in_target  input  WIDTH  branch target PC.
REQ-011 SHALL have ports in_rd (input, 4, destination register), in_wr_en (input, 1, register write), in_mem_rd (input, 1, load), in_mem_wr (input, 1, store), in_store_data (input, WIDTH, store data).
REQ-012 SHALL have port flush  input  1  external kill of all stage state (exception).
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1, memory stage accepts), out_result, out_rd, out_wr_en, out_mem_rd, out_mem_wr, out_store_data (registered copies of the inputs).
REQ-014 SHALL have ports redirect_valid (output, 1, one-cycle pulse) and redirect_pc (output, WIDTH).
REQ-015 SHALL have ports fwd_valid (output, 1), fwd_rd (output, 4), fwd_data (output, WIDTH) for operand forwarding to execute.
REQ-016 SHALL have port branch_count  output  16  taken-branch counter, wraps 0xFFFF->0.

Function
REQ-017 in_ready SHALL equal (~out_valid | out_ready), combinationally; accept = in_valid & in_ready.
REQ-018 On accept of a non-squashed instruction, SHALL register all payload fields and set out_valid=1 next cycle (latency 1).
REQ-019 When out_valid & out_ready and no accept, SHALL clear out_valid; payload registers SHALL hold while out_valid & ~out_ready.
REQ-020 Squash state: counter sq_left (0..SQUASH_CNT); RUN when sq_left==0, SQUASH otherwise.
REQ-021 Accept of a branch with in_is_branch & in_taken in RUN SHALL: register it normally, pulse redirect_valid=1 with redirect_pc=in_target next cycle, load sq_left=SQUASH_CNT, increment branch_count.
REQ-022 Accept in SQUASH SHALL drop the instruction (out_valid not set by it), decrement sq_left, and SHALL NOT redirect or count even if it is a taken branch.
REQ-023 Cycles without accept SHALL leave sq_left unchanged.
REQ-024 Not-taken branches SHALL pass through with no redirect and no count change.
REQ-025 flush=1 SHALL, next cycle, clear out_valid, sq_left, redirect_valid; flush SHALL override a simultaneous accept; branch_count SHALL hold.
REQ-026 fwd_valid SHALL equal out_valid & out_wr_en & ~out_mem_rd; fwd_rd=out_rd; fwd_data=out_result.
REQ-027 redirect_valid SHALL be high for exactly one cycle per redirecting branch, independent of out_ready.

Reset
REQ-028 With rst_n=0 at a rising edge, SHALL set out_valid=0, redirect_valid=0, redirect_pc=0, sq_left=0, branch_count=0, all payload outputs 0; reset SHALL override flush and accept, including mid-squash.

Verification
REQ-029 ALU op add result 0x0005, rd=3, wr_en=1, out_ready=1 -> next cycle out_valid=1, out_result=0x0005, fwd_valid=1, fwd_rd=3.
REQ-030 Taken branch target 0x0040, then three back-to-back adds, SQUASH_CNT=2 -> redirect_valid one cycle with 0x0040, first two adds dropped, third appears, branch_count=1.
REQ-031 out_ready=0 with out_valid=1 -> in_ready=0, payload holds 4 cycles; out_ready=1 -> drains, in_ready=1.
REQ-032 Taken branch arriving as first squash-shadow instruction -> no redirect, branch_count unchanged, sq_left 2->1.
REQ-033 flush asserted with in_valid=1 during SQUASH -> next cycle out_valid=0, sq_left=0, next taken branch redirects.
REQ-034 rst_n=0 for one cycle mid-squash with branch_count=0xFFFF -> all outputs 0; prior wrap: 0xFFFF + taken branch -> 0x0000.

Source files
------------

// File: rtl/exmem_stage.sv
`default_nettype none
// ============================================================================
// exmem_stage : execute-to-memory pipeline register with taken-branch redirect,
//               squash shadow for younger instructions, forwarding tap and a
//               wrapping taken-branch counter.
// Revision    : 1.0
// ============================================================================
module exmem_stage #(
  parameter int WIDTH      = 16,
  parameter int SQUASH_CNT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  // execute side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_taken,
  input  logic             in_is_branch,
  input  logic [WIDTH-1:0] in_target,
  input  logic [3:0]       in_rd,
  input  logic             in_wr_en,
  input  logic             in_mem_rd,
  input  logic             in_mem_wr,
  input  logic [WIDTH-1:0] in_store_data,
  input  logic             flush,
  // memory side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_rd,
  output logic             out_wr_en,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic [WIDTH-1:0] out_store_data,
  // fetch redirect
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  // forwarding to execute
  output logic             fwd_valid,
  output logic [3:0]       fwd_rd,
  output logic [WIDTH-1:0] fwd_data,
  output logic [15:0]      branch_count
);

  localparam int              SQ_W    = 2;
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CNT);
  localparam logic [SQ_W-1:0] SQ_ONE  = SQ_W'(1);

  if (SQUASH_CNT < 1 || SQUASH_CNT > 3) begin : g_bad_squash_cnt
    $error("exmem_stage: SQUASH_CNT must be in 1..3");
  end

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } mode_t;

  logic [SQ_W-1:0] sq_left;
  mode_t           mode;
  logic            accept;
  logic            take;
  logic            redirect_now;

  always_comb begin
    mode = RUN;
    if (sq_left != '0) begin
      mode = SQUASH;
    end
  end

  assign in_ready     = ~out_valid | out_ready;
  assign accept       = in_valid & in_ready;
  // flush kills whatever is being accepted in the same cycle
  assign take         = accept & (mode == RUN) & ~flush;
  assign redirect_now = take & in_is_branch & in_taken;

  assign fwd_valid = out_valid & out_wr_en & ~out_mem_rd;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      sq_left        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      branch_count   <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      sq_left        <= '0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= redirect_now;
      if (take) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (redirect_now) begin
        redirect_pc  <= in_target;
        sq_left      <= SQ_LOAD;
        branch_count <= branch_count + 16'd1;
      end else if (accept && mode == SQUASH) begin
        sq_left <= sq_left - SQ_ONE;
      end
    end
  end

  // Payload only moves on a real (non-squashed, non-flushed) accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_result     <= '0;
      out_rd         <= '0;
      out_wr_en      <= 1'b0;
      out_mem_rd     <= 1'b0;
      out_mem_wr     <= 1'b0;
      out_store_data <= '0;
    end else if (take) begin
      out_result     <= in_result;
      out_rd         <= in_rd;
      out_wr_en      <= in_wr_en;
      out_mem_rd     <= in_mem_rd;
      out_mem_wr     <= in_mem_wr;
      out_store_data <= in_store_data;
    end
  end

endmodule
`default_nettype wire
